// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers for the EX stage.
// Optional MADD/MADDU accumulate is enabled by defining MDU_MADD_EN.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MADDU = 3'd7;

    localparam logic [4:0] MULT_LAST = 5'(MULT_CYCLES - 1);
    localparam logic [4:0] DIV_LAST  = 5'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    // Odd opcodes (MULTU, DIVU, MADDU) are the unsigned variants.
    logic        is_signed;
    logic [63:0] ext_a, ext_b, prod;
    logic [31:0] mag_a, mag_b, divisor, uq, ur, quot, rem;
    logic [63:0] result;
    logic        write_en;

    assign is_signed = ~op_q[0];
    assign ext_a     = {{32{a_q[31] & is_signed}}, a_q};
    assign ext_b     = {{32{b_q[31] & is_signed}}, b_q};
    assign prod      = ext_a * ext_b;

    // Signed divide works on magnitudes; -2^31 / -1 falls out as 0x80000000 rem 0.
    assign mag_a   = (is_signed && a_q[31]) ? -a_q : a_q;
    assign mag_b   = (is_signed && b_q[31]) ? -b_q : b_q;
    assign divisor = (b_q == 32'd0) ? 32'd1 : mag_b;
    assign uq      = mag_a / divisor;
    assign ur      = mag_a % divisor;
    assign quot    = (is_signed && (a_q[31] ^ b_q[31])) ? -uq : uq;
    assign rem     = (is_signed && a_q[31]) ? -ur : ur;

    always_comb begin
        result   = {hi_q, lo_q};
        write_en = 1'b1;
        case (op_q)
            OP_MULT, OP_MULTU: result = prod;
            OP_DIV, OP_DIVU: begin
                result   = {rem, quot};
                write_en = (b_q != 32'd0);
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: result = {hi_q, lo_q} + prod;
`endif
            default: result = {hi_q, lo_q};
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MTHI: hi_d = rs;
                        OP_MTLO: lo_d = rs;
                        OP_MULT, OP_MULTU: begin
                            a_d = rs; b_d = rt; op_d = op;
                            cnt_d   = MULT_LAST;
                            state_d = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            a_d = rs; b_d = rt; op_d = op;
                            cnt_d   = DIV_LAST;
                            state_d = RUN;
                        end
`ifdef MDU_MADD_EN
                        OP_MADD, OP_MADDU: begin
                            a_d = rs; b_d = rt; op_d = op;
                            cnt_d   = MULT_LAST;
                            state_d = RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt_q == 5'd0) begin
                    state_d = IDLE;
                    if (write_en) begin
                        hi_d = result[63:32];
                        lo_d = result[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 3'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed plan cases plus random ops vs a reference model.
// Handshake: start is a one-cycle pulse; a long op completes on the cycle busy falls, hi/lo valid then.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs = 32'd0;
  logic [31:0] rt = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] exp_q[$];
  int          len_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          busy_cnt = 0;
  bit          madd_on;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain SV arithmetic on {hi,lo}.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] cur);
    longint      sp;
    logic [63:0] up;
    int          q, r;
    sp = longint'(int'(a)) * longint'(int'(b));
    up = {32'd0, a} * {32'd0, b};
    case (o)
      3'd0: return sp;
      3'd1: return up;
      3'd2: begin
        if (b == 32'd0) return cur;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
        return {r, q};
      end
      3'd3: return (b == 32'd0) ? cur : {a % b, a / b};
      3'd4: return {a, cur[31:0]};
      3'd5: return {cur[63:32], a};
      3'd6: return madd_on ? cur + sp : cur;
      default: return madd_on ? cur + up : cur;
    endcase
  endfunction

  function automatic bit is_long(input logic [2:0] o);
    return (o <= 3'd3) || (madd_on && o >= 3'd6);
  endfunction

  task automatic pulse(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      n_vec++; n_err++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", t);
    end
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] nxt;
    nxt = model(o, a, b, {m_hi, m_lo});
    if (is_long(o)) begin
      exp_q.push_back(nxt);
      len_q.push_back((o == 3'd2 || o == 3'd3) ? 10 : 5);
    end
    {m_hi, m_lo} = nxt;
    pulse(o, a, b);
    if (!is_long(o)) begin
      chk("short_busy", {63'd0, busy}, 64'd0);
      chk("short_hilo", {hi, lo}, {m_hi, m_lo});
    end
    wait_idle();
  endtask

  // Monitor: a completed operation is presented on the cycle busy falls.
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
    end else if (busy) begin
      busy_cnt++;
    end else if (busy_cnt > 0) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL mon_unexpected: completion with hilo=%h, required none", {hi, lo});
      end else begin
        chk("mon_hilo", {hi, lo}, exp_q.pop_front());
        chk("mon_busy_len", 64'(busy_cnt), 64'(len_q.pop_front()));
      end
      busy_cnt = 0;
    end
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
`ifdef MDU_MADD_EN
    madd_on = 1'b1;
`else
    madd_on = 1'b0;
`endif
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    do_op(3'd0, 32'hFFFF_FFFE, 32'd3);
    chk("mult_neg2x3", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    do_op(3'd1, 32'hFFFF_FFFE, 32'd3);
    chk("multu", {hi, lo}, {32'h0000_0002, 32'hFFFF_FFFA});
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg7_2", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_op(3'd3, 32'd7, 32'd2);
    chk("divu_7_2", {hi, lo}, {32'd1, 32'd3});
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf", {hi, lo}, {32'd0, 32'h8000_0000});

    do_op(3'd4, 32'h1234, 32'd0);
    do_op(3'd5, 32'h5678, 32'd0);
    do_op(3'd2, 32'd99, 32'd0);
    chk("div_by_zero", {hi, lo}, {32'h1234, 32'h5678});

    // start during busy must be ignored, as must later rs/rt changes.
    exp_q.push_back(64'h0000_0000_0000_2A00);
    len_q.push_back(5);
    {m_hi, m_lo} = 64'h0000_0000_0000_2A00;
    pulse(3'd0, 32'h100, 32'h2A);
    pulse(3'd5, 32'hDEAD, 32'h7);
    rs = 32'hFFFF_FFFF; rt = 32'hFFFF_FFFF;
    wait_idle();
    chk("ignored_start", {hi, lo}, 64'h0000_0000_0000_2A00);

    // Asynchronous reset mid-divide.
    do_op(3'd4, 32'hAAAA, 32'd0);
    exp_q.push_back(64'd0);
    len_q.push_back(10);
    pulse(3'd3, 32'd1000, 32'd7);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    exp_q.delete();
    len_q.delete();
    {m_hi, m_lo} = 64'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    do_op(3'd0, 32'd6, 32'd7);
    chk("mult_after_rst", {hi, lo}, 64'd42);

    do_op(3'd4, 32'd0, 32'd0);
    do_op(3'd5, 32'hFFFF_FFFF, 32'd0);
    do_op(3'd7, 32'd1, 32'd1);
    if (madd_on) chk("maddu", {hi, lo}, {32'd1, 32'd0});
    else         chk("maddu_noop", {hi, lo}, {32'd0, 32'hFFFF_FFFF});

    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      do_op(ro, ra, rb);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("final_hilo", {hi, lo}, {m_hi, m_lo});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
